imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Write side of the 32 x 32-bit instruction memory. The processor's fetch path reads that memory combinationally, indexed by addr[4:0].
// - Accepts a byte stream over a valid/ready handshake and packs each 4 bytes little-endian into a 32-bit instruction.
// - Writes the packed words to consecutive word indices starting at 0.
// - Holds the CPU off the fetch path until the program image is complete.
// PARAMETERS
// - DEPTH   32  number of instruction words in IMEM; word index width = $clog2(DEPTH) = 5
// - WORD_W  32  instruction width in bits; must be 4 x 8
// PORTS
// - clk            in   1   single clock; all state updates on posedge
// - rst            in   1   synchronous, active-high reset
// - start          in   1   pulse; begins a load (sampled in IDLE or DONE only)
// - load_len       in   6   words to load, sampled with start; 0..32, values >DEPTH clamp to DEPTH
// - in_valid       in   1   byte-stream valid
// - in_data        in   8   byte-stream data
// - in_ready       out  1   byte-stream ready; byte accepted when in_valid && in_ready
// - imem_we        out  1   IMEM write enable, one-cycle pulse per word
// - imem_waddr     out  64  word index (zero-extended); IMEM decodes bits [4:0]
// - imem_wdata     out  32  packed instruction
// - busy           out  1   load in progress (LOAD or WRITE state)
// - done           out  1   load complete; held until the next start or rst
// - cpu_hold       out  1   1 = processor stalled/held; 0 only in DONE
// - words_written  out  6   count of words written in the current load
// BEHAVIOUR
// - Reset values (rst sampled high at posedge, any state, including mid-load):
//   state=IDLE, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, cpu_hold=1,
//   words_written=0, byte_cnt=0.
// - No partial word is written on reset.
// - FSM states: IDLE, LOAD, WRITE, DONE. All outputs are registered or decoded purely from state.
// - IDLE:
//   - start=1, effective len=0 -> DONE next cycle, no writes.
//   - start=1, len>0 -> LOAD; clear words_written, byte_cnt, imem_wdata.
// - LOAD:
//   - in_ready=1, busy=1.
//   - On each accepted byte: imem_wdata[8*byte_cnt +: 8] <= in_data; byte_cnt++.
//   - On acceptance of the 4th byte (byte_cnt==3) -> WRITE; byte_cnt wraps to 0.
//   - Bubbles (in_valid=0) simply wait; there is no timeout.
// - WRITE (exactly 1 cycle):
//   - in_ready=0, imem_we=1, imem_waddr=words_written, imem_wdata stable.
//   - Next cycle: words_written++.
//   - If the incremented count == effective len -> DONE, else -> LOAD.
// - DONE:
//   - done=1, busy=0, cpu_hold=0, in_ready=0.
//   - start=1 -> restart exactly as from IDLE; done and cpu_hold return to 0/1 the next cycle.
// - start while in LOAD or WRITE is ignored. Bytes offered outside LOAD are not accepted.
// - Write address never exceeds DEPTH-1; a full load writes indices 0..31 and ends with words_written=32.
// - Latency: the write pulse occurs in the cycle after the 4th byte is accepted.
//   Back-to-back input gives 5 cycles per word.
// TESTING
// - rst high 2 cycles -> cpu_hold=1, done=0, busy=0, in_ready=0, imem_we=0, words_written=0.
// - start, len=1, bytes 0x13,0x05,0x10,0x00 back-to-back -> one imem_we pulse,
//   waddr=0, wdata=0x00100513; done=1, cpu_hold=0 on the following cycle.
// - start, len=32, 128 bytes with random in_valid gaps -> 32 writes at waddr 0..31, data matches the model,
//   words_written=32, no extra writes, in_ready=0 during every WRITE cycle.
// - start, len=0 -> DONE after one cycle, zero imem_we pulses; len=40 -> exactly 32 writes.
// - rst asserted after 2 bytes of word 3 -> next cycle IDLE, cpu_hold=1, no write of the partial word;
//   a new load then starts at waddr=0.
// - start pulsed during LOAD -> ignored (count unchanged); start in DONE -> reload overwrites from waddr 0.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Packs a little-endian byte stream into 32-bit words and writes
//            them to instruction memory, holding the CPU until loading is done.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   load_len,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     imem_we,
    output logic [63:0]              imem_waddr,
    output logic [WORD_W-1:0]        imem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_hold,
    output logic [$clog2(DEPTH):0]   words_written
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH_LEN = (c_AW+1)'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        r_byte_cnt;
    logic [WORD_W-1:0] r_wdata;
    logic [c_AW-1:0]   r_waddr;
    logic [c_AW:0]     r_words_written;
    logic [c_AW:0]     r_len;

    logic [c_AW:0]     w_eff_len;
    logic [c_AW:0]     w_ww_next;

    assign w_eff_len = (load_len > c_DEPTH_LEN) ? c_DEPTH_LEN : load_len;
    assign w_ww_next = r_words_written + (c_AW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_byte_cnt      <= 2'd0;
            r_wdata         <= '0;
            r_waddr         <= '0;
            r_words_written <= '0;
            r_len           <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_len           <= w_eff_len;
                        r_words_written <= '0;
                        r_byte_cnt      <= 2'd0;
                        r_wdata         <= '0;
                        r_waddr         <= '0;
                        r_state         <= (w_eff_len == '0) ? c_DONE : c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (in_valid) begin
                        r_wdata[{r_byte_cnt, 3'b000} +: 8] <= in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Address is latched here so it stays stable through the write pulse
                        if (r_byte_cnt == 2'd3) begin
                            r_waddr <= r_words_written[c_AW-1:0];
                            r_state <= c_WRITE;
                        end
                    end
                end
                c_WRITE: begin
                    r_words_written <= w_ww_next;
                    r_state         <= (w_ww_next == r_len) ? c_DONE : c_LOAD;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == c_LOAD);
    assign imem_we       = (r_state == c_WRITE);
    assign busy          = (r_state == c_LOAD) || (r_state == c_WRITE);
    assign done          = (r_state == c_DONE);
    assign cpu_hold      = (r_state != c_DONE);
    assign imem_waddr    = {{(64-c_AW){1'b0}}, r_waddr};
    assign imem_wdata    = r_wdata;
    assign words_written = r_words_written;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  load_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic [5:0]  words_written;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Write monitor state
    int          wr_cnt    = 0;
    int          bad_ready = 0;
    logic [63:0] log_addr [0:255];
    logic [31:0] log_data [0:255];

    imem_loader #(.DEPTH(32), .WORD_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_len      (load_len),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .busy          (busy),
        .done          (done),
        .cpu_hold      (cpu_hold),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 256) begin
                log_addr[wr_cnt] = imem_waddr;
                log_data[wr_cnt] = imem_wdata;
            end
            if (in_ready !== 1'b0) bad_ready++;
            wr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
    endtask

    // Offer a byte after 'gap' idle cycles; returns one cycle after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (gap_max == 0) ? 0 : $urandom_range(0, gap_max));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_done", {63'd0, done}, 64'd1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
        chk("rst_words_written", {58'd0, words_written}, 64'd0);
        chk("rst_waddr", imem_waddr, 64'd0);
        chk("rst_wdata", {32'd0, imem_wdata}, 64'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int base;
        base = wr_cnt;
        do_start(6'd1);
        chk("single_busy", {63'd0, busy}, 64'd1);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        chk("single_we", {63'd0, imem_we}, 64'd1);
        chk("single_ready_in_write", {63'd0, in_ready}, 64'd0);
        chk("single_waddr", imem_waddr, 64'd0);
        chk("single_wdata", {32'd0, imem_wdata}, 64'h00100513);
        tick();
        chk("single_done", {63'd0, done}, 64'd1);
        chk("single_cpu_hold", {63'd0, cpu_hold}, 64'd0);
        chk("single_busy_after", {63'd0, busy}, 64'd0);
        chk("single_words_written", {58'd0, words_written}, 64'd1);
        chk("single_write_count", 64'(wr_cnt - base), 64'd1);
    endtask

    // Loads len words (bytes derived from seed) and checks address order and data.
    task automatic full_load(input string tag, input logic [5:0] len, input int gap_max, input int seed);
        int base;
        logic [31:0] w;
        base = wr_cnt;
        bad_ready = 0;
        do_start(len);
        for (int i = 0; i < 32; i++) begin
            w = {8'(4*i*seed + 3*seed + 1), 8'(4*i*seed + 2*seed + 1),
                 8'(4*i*seed + seed + 1),   8'(4*i*seed + 1)};
            send_word(w, gap_max);
        end
        wait_done();
        repeat (5) tick();
        chk({tag, "_write_count"}, 64'(wr_cnt - base), 64'd32);
        chk({tag, "_words_written"}, {58'd0, words_written}, 64'd32);
        chk({tag, "_ready_during_write"}, 64'(bad_ready), 64'd0);
        chk({tag, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            w = {8'(4*i*seed + 3*seed + 1), 8'(4*i*seed + 2*seed + 1),
                 8'(4*i*seed + seed + 1),   8'(4*i*seed + 1)};
            chk({tag, "_waddr"}, log_addr[base + i], 64'(i));
            chk({tag, "_wdata"}, {32'd0, log_data[base + i]}, {32'd0, w});
        end
    endtask

    task automatic test_len_zero();
        int base;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("zero_idle_hold", {63'd0, cpu_hold}, 64'd1);
        base = wr_cnt;
        do_start(6'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_cpu_hold", {63'd0, cpu_hold}, 64'd0);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        chk("zero_write_count", 64'(wr_cnt - base), 64'd0);
    endtask

    task automatic test_reset_midload();
        int base;
        base = wr_cnt;
        do_start(6'd4);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'h99AABBCC, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst_words_written", {58'd0, words_written}, 64'd0);
        repeat (4) tick();
        chk("midrst_write_count", 64'(wr_cnt - base), 64'd3);
        base = wr_cnt;
        do_start(6'd1);
        send_word(32'hCAFEF00D, 0);
        wait_done();
        chk("midrst_reload_count", 64'(wr_cnt - base), 64'd1);
        chk("midrst_reload_waddr", log_addr[base], 64'd0);
        chk("midrst_reload_wdata", {32'd0, log_data[base]}, 64'hCAFEF00D);
    endtask

    task automatic test_start_during_load();
        int base;
        base = wr_cnt;
        do_start(6'd2);
        chk("restart_hold", {63'd0, cpu_hold}, 64'd1);
        chk("restart_done", {63'd0, done}, 64'd0);
        send_word(32'hA1B2C3D4, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        do_start(6'd5);
        chk("ign_start_busy", {63'd0, busy}, 64'd1);
        chk("ign_start_words", {58'd0, words_written}, 64'd1);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        wait_done();
        chk("ign_start_words_final", {58'd0, words_written}, 64'd2);
        chk("ign_start_count", 64'(wr_cnt - base), 64'd2);
        chk("ign_start_w1_addr", log_addr[base + 1], 64'd1);
        chk("ign_start_w1_data", {32'd0, log_data[base + 1]}, 64'h12345678);
    endtask

    task automatic test_back_to_back();
        int base;
        int cyc;
        base = wr_cnt;
        do_start(6'd2);
        cyc = 0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        while (wr_cnt - base < 2 && cyc < 30) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        // Second write pulse lands in cycle 10 after start: 2 words x 5 cycles.
        chk("b2b_cycles", 64'(cyc), 64'd10);
        wait_done();
        chk("b2b_wdata", {32'd0, log_data[base + 1]}, 64'h5A5A5A5A);
    endtask

    initial begin
        test_reset();
        test_single_word();
        full_load("full", 6'd32, 2, 7);
        test_len_zero();
        full_load("clamp", 6'd40, 0, 13);
        test_reset_midload();
        test_start_during_load();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
